// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  // Client index width; a 2-client arbiter still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first requester after `last`, wrapping modulo N.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % N);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter sharing one burst-capable memory master among N clients.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     c_addr,
  input  logic [NUM_CLIENTS*BURSTLEN_WIDTH-1:0] c_burst_len,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     c_data_in,
  input  logic [NUM_CLIENTS-1:0]                c_wr,
  input  logic [NUM_CLIENTS-1:0]                c_rd,
  output logic [DATA_WIDTH-1:0]                 c_data_out,
  output logic [NUM_CLIENTS-1:0]                c_waitrequest,
  output logic [NUM_CLIENTS-1:0]                c_rd_valid,
  output logic [ADDR_WIDTH-1:0]                 mm_addr,
  output logic [BURSTLEN_WIDTH-1:0]             mm_burst_len,
  output logic [DATA_WIDTH-1:0]                 mm_data_out,
  output logic                                  mm_wr,
  output logic                                  mm_rd,
  input  logic [DATA_WIDTH-1:0]                 mm_data_in,
  input  logic                                  mm_waitrequest,
  input  logic                                  mm_rd_valid,
  output logic                                  err_stray_rd_valid
);

  localparam int IW = idx_width(NUM_CLIENTS);

  arb_state_t                state, state_nxt;
  logic [IW-1:0]             owner, last;
  logic [BURSTLEN_WIDTH-1:0] cnt, cnt_nxt;
  logic                      err_q;
  logic                      gnt_vld;
  logic [IW-1:0]             gnt_idx;
  logic                      own_rd, own_wr, in_cmd, rd_acc, wr_acc;

  logic [ADDR_WIDTH-1:0]     addr_a [NUM_CLIENTS];
  logic [BURSTLEN_WIDTH-1:0] blen_a [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]     wdat_a [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_a[g] = c_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign blen_a[g] = c_burst_len[g*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
    assign wdat_a[g] = c_data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_pick (
    .req     (c_rd | c_wr),
    .last    (last),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // A simultaneous read and write from the owner is served as a read.
  assign in_cmd = (state == CMD);
  assign own_rd = c_rd[owner];
  assign own_wr = c_wr[owner] & ~own_rd;
  assign rd_acc = in_cmd & own_rd & ~mm_waitrequest;
  assign wr_acc = in_cmd & own_wr & ~mm_waitrequest;

  assign mm_addr            = addr_a[owner];
  assign mm_burst_len       = blen_a[owner];
  assign mm_data_out        = wdat_a[owner];
  assign mm_rd              = in_cmd & own_rd;
  assign mm_wr              = in_cmd & own_wr;
  assign c_data_out         = mm_data_in;
  assign err_stray_rd_valid = err_q;

  always_comb begin
    c_waitrequest = '1;
    c_rd_valid    = '0;
    if (in_cmd) c_waitrequest[owner] = mm_waitrequest;
    if (state == RD_WAIT) c_rd_valid[owner] = mm_rd_valid;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nxt = CMD;
          cnt_nxt   = blen_a[gnt_idx];
        end
      end
      CMD: begin
        if (!own_rd && !own_wr) begin
          state_nxt = IDLE;
        end else if (rd_acc) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = blen_a[owner];
        end else if (wr_acc) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      RD_WAIT: begin
        if (mm_rd_valid) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to the top index so client 0 is first after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_CLIENTS - 1);
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && gnt_vld) begin
        owner <= gnt_idx;
        last  <= gnt_idx;
      end
      if (mm_rd_valid && state != RD_WAIT) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Scoreboard bench for mem_arb_rr: grant order, bursts, stray beats, reset.
module tb_mem_arb_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*AW-1:0] c_addr = '0;
  logic [N*BW-1:0] c_burst_len = '0;
  logic [N*DW-1:0] c_data_in = '0;
  logic [N-1:0]    c_wr = '0;
  logic [N-1:0]    c_rd = '0;
  logic [DW-1:0]   c_data_out;
  logic [N-1:0]    c_waitrequest;
  logic [N-1:0]    c_rd_valid;
  logic [AW-1:0]   mm_addr;
  logic [BW-1:0]   mm_burst_len;
  logic [DW-1:0]   mm_data_out;
  logic            mm_wr;
  logic            mm_rd;
  logic [DW-1:0]   mm_data_in = '0;
  logic            mm_waitrequest = 1'b0;
  logic            mm_rd_valid = 1'b0;
  logic            err_stray_rd_valid;

  int checks = 0;
  int failures = 0;
  int            exp_gnt_q[$];
  logic [DW-1:0] exp_data_q[$];

  mem_arb_rr #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .c_addr             (c_addr),
    .c_burst_len        (c_burst_len),
    .c_data_in          (c_data_in),
    .c_wr               (c_wr),
    .c_rd               (c_rd),
    .c_data_out         (c_data_out),
    .c_waitrequest      (c_waitrequest),
    .c_rd_valid         (c_rd_valid),
    .mm_addr            (mm_addr),
    .mm_burst_len       (mm_burst_len),
    .mm_data_out        (mm_data_out),
    .mm_wr              (mm_wr),
    .mm_rd              (mm_rd),
    .mm_data_in         (mm_data_in),
    .mm_waitrequest     (mm_waitrequest),
    .mm_rd_valid        (mm_rd_valid),
    .err_stray_rd_valid (err_stray_rd_valid)
  );

  always #5 clock = ~clock;

  // Index of the single deasserted waitrequest bit, -1 if not exactly one.
  function automatic int sole_zero(input logic [N-1:0] v);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i] === 1'b0) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (c_waitrequest !== 4'hF) begin failures++; $display("FAIL reset_waitreq got=%h exp=f", c_waitrequest); end
    checks++; if (c_rd_valid !== 4'h0) begin failures++; $display("FAIL reset_rd_valid got=%h exp=0", c_rd_valid); end
    checks++; if ({mm_rd, mm_wr} !== 2'b00) begin failures++; $display("FAIL reset_mm_cmd got=%b exp=00", {mm_rd, mm_wr}); end
    checks++; if (err_stray_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_stray_rd_valid); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_rr_reads();
    int cyc = 0, grants = 0, exp_acc = 1, cur = 0, g, e;
    bit pend = 0, done = 0;
    logic [N-1:0] exp_v;
    @(negedge clock);
    c_burst_len = '0; c_rd = 4'hF; mm_waitrequest = 1'b0; mm_rd_valid = 1'b0;
    for (int k = 0; k < 5; k++) exp_gnt_q.push_back(k % N);
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      mm_rd_valid = pend;
      pend = 0;
      #1;
      if (mm_rd_valid) begin
        exp_v = 4'b0001 << cur;
        checks++; if (c_rd_valid !== exp_v) begin failures++; $display("FAIL rr_rd_valid got=%b exp=%b", c_rd_valid, exp_v); end
        if (grants == 5) done = 1;
      end else if (mm_rd && exp_gnt_q.size() > 0) begin
        g = sole_zero(c_waitrequest);
        e = exp_gnt_q.pop_front();
        checks++; if (g !== e) begin failures++; $display("FAIL rr_grant got=%0d exp=%0d", g, e); end
        checks++; if (cyc !== exp_acc) begin failures++; $display("FAIL rr_latency cycle got=%0d exp=%0d", cyc, exp_acc); end
        exp_acc = cyc + 3;
        cur = e;
        grants++;
        pend = 1;
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL rr_timeout grants got=%0d exp=5", grants); end
    @(negedge clock);
    c_rd = '0; mm_rd_valid = 1'b0;
    exp_gnt_q.delete();
  endtask

  task automatic test_read_burst();
    int beats = 0;
    logic [DW-1:0] d;
    @(negedge clock);
    c_rd = 4'b0100; c_burst_len[2*BW +: BW] = 2'd3; mm_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) exp_data_q.push_back(32'hD00D_0000 + k);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); #1;
      checks++; if (!(mm_rd === 1'b1 && c_waitrequest === 4'hF)) begin failures++; $display("FAIL burst_stall rd=%b waitreq=%h exp rd=1 waitreq=f", mm_rd, c_waitrequest); end
    end
    checks++; if (mm_addr !== c_addr[2*AW +: AW]) begin failures++; $display("FAIL burst_addr got=%h exp=%h", mm_addr, c_addr[2*AW +: AW]); end
    checks++; if (mm_burst_len !== 2'd3) begin failures++; $display("FAIL burst_len got=%0d exp=3", mm_burst_len); end
    @(negedge clock);
    mm_waitrequest = 1'b0;
    #1;
    checks++; if (!(mm_rd === 1'b1 && c_waitrequest === 4'b1011)) begin failures++; $display("FAIL burst_accept rd=%b waitreq=%b exp rd=1 waitreq=1011", mm_rd, c_waitrequest); end
    for (int c = 0; c < 12 && beats < 4; c++) begin
      @(negedge clock);
      c_rd = '0;
      if (c == 1 || c == 4) begin
        mm_rd_valid = 1'b0;
        #1;
        checks++; if (c_rd_valid !== 4'b0000) begin failures++; $display("FAIL burst_gap_valid got=%b exp=0000", c_rd_valid); end
      end else begin
        d = exp_data_q.pop_front();
        mm_rd_valid = 1'b1; mm_data_in = d;
        #1;
        checks++; if (c_rd_valid !== 4'b0100) begin failures++; $display("FAIL burst_beat_valid got=%b exp=0100", c_rd_valid); end
        checks++; if (c_data_out !== d) begin failures++; $display("FAIL burst_beat_data got=%h exp=%h", c_data_out, d); end
        beats++;
      end
    end
    @(negedge clock);
    mm_rd_valid = 1'b0; c_rd = 4'b1000; c_burst_len[3*BW +: BW] = '0;
    #1;
    checks++; if (!(mm_rd === 1'b0 && c_waitrequest === 4'hF)) begin failures++; $display("FAIL burst_idle rd=%b waitreq=%h exp rd=0 waitreq=f", mm_rd, c_waitrequest); end
    @(negedge clock); #1;
    checks++; if (!(mm_rd === 1'b1 && sole_zero(c_waitrequest) == 3)) begin failures++; $display("FAIL burst_next_grant rd=%b waitreq=%b exp rd=1 waitreq=0111", mm_rd, c_waitrequest); end
    c_rd = '0;
    @(negedge clock); #1;
    checks++; if (mm_rd !== 1'b0) begin failures++; $display("FAIL withdraw_rd got=%b exp=0", mm_rd); end
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] d;
    @(negedge clock);
    exp_data_q.push_back(32'hAAAA_0001);
    exp_data_q.push_back(32'hBBBB_0002);
    c_wr = 4'b0010; c_burst_len[1*BW +: BW] = 2'd1; c_data_in[1*DW +: DW] = exp_data_q[0];
    mm_waitrequest = 1'b0;
    @(negedge clock); #1;
    d = exp_data_q.pop_front();
    checks++; if (!(mm_wr === 1'b1 && mm_rd === 1'b0)) begin failures++; $display("FAIL wr_beat1_cmd wr=%b rd=%b exp wr=1 rd=0", mm_wr, mm_rd); end
    checks++; if (mm_data_out !== d) begin failures++; $display("FAIL wr_beat1_data got=%h exp=%h", mm_data_out, d); end
    checks++; if (sole_zero(c_waitrequest) != 1) begin failures++; $display("FAIL wr_owner waitreq=%b exp=1101", c_waitrequest); end
    @(negedge clock);
    c_data_in[1*DW +: DW] = exp_data_q[0];
    #1;
    d = exp_data_q.pop_front();
    checks++; if (mm_wr !== 1'b1) begin failures++; $display("FAIL wr_beat2_cmd got=%b exp=1", mm_wr); end
    checks++; if (mm_data_out !== d) begin failures++; $display("FAIL wr_beat2_data got=%h exp=%h", mm_data_out, d); end
    @(negedge clock); #1;
    checks++; if (!(mm_wr === 1'b0 && c_waitrequest === 4'hF)) begin failures++; $display("FAIL wr_idle wr=%b waitreq=%h exp wr=0 waitreq=f", mm_wr, c_waitrequest); end
    @(negedge clock); #1;
    checks++; if (mm_wr !== 1'b1) begin failures++; $display("FAIL wr_regrant got=%b exp=1", mm_wr); end
    c_rd[1] = 1'b1;
    #1;
    checks++; if (!(mm_rd === 1'b1 && mm_wr === 1'b0)) begin failures++; $display("FAIL rd_wins rd=%b wr=%b exp rd=1 wr=0", mm_rd, mm_wr); end
    c_rd = '0; c_wr = '0;
    #1;
    checks++; if ({mm_rd, mm_wr} !== 2'b00) begin failures++; $display("FAIL wr_withdraw got=%b exp=00", {mm_rd, mm_wr}); end
    @(negedge clock); #1;
    checks++; if (c_waitrequest !== 4'hF) begin failures++; $display("FAIL wr_withdraw_idle got=%h exp=f", c_waitrequest); end
  endtask

  task automatic test_stray();
    @(negedge clock); #1;
    checks++; if (err_stray_rd_valid !== 1'b0) begin failures++; $display("FAIL stray_pre got=%b exp=0", err_stray_rd_valid); end
    mm_rd_valid = 1'b1;
    #1;
    checks++; if (c_rd_valid !== 4'b0000) begin failures++; $display("FAIL stray_routed got=%b exp=0000", c_rd_valid); end
    @(negedge clock);
    mm_rd_valid = 1'b0;
    #1;
    checks++; if (err_stray_rd_valid !== 1'b1) begin failures++; $display("FAIL stray_set got=%b exp=1", err_stray_rd_valid); end
    repeat (3) @(negedge clock);
    #1;
    checks++; if (err_stray_rd_valid !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b exp=1", err_stray_rd_valid); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    c_rd = 4'b0010; c_burst_len[1*BW +: BW] = 2'd3; mm_waitrequest = 1'b0;
    @(negedge clock); #1;
    checks++; if (!(mm_rd === 1'b1 && sole_zero(c_waitrequest) == 1)) begin failures++; $display("FAIL mid_accept rd=%b waitreq=%b exp rd=1 waitreq=1101", mm_rd, c_waitrequest); end
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      c_rd = '0; mm_rd_valid = 1'b1; mm_data_in = 32'hBEEF_0000 + b;
      #1;
      checks++; if (c_rd_valid !== 4'b0010) begin failures++; $display("FAIL mid_beat got=%b exp=0010", c_rd_valid); end
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if (c_waitrequest !== 4'hF) begin failures++; $display("FAIL mid_rst_waitreq got=%h exp=f", c_waitrequest); end
    checks++; if (c_rd_valid !== 4'h0) begin failures++; $display("FAIL mid_rst_rd_valid got=%b exp=0000", c_rd_valid); end
    checks++; if ({mm_rd, mm_wr} !== 2'b00) begin failures++; $display("FAIL mid_rst_cmd got=%b exp=00", {mm_rd, mm_wr}); end
    checks++; if (err_stray_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", err_stray_rd_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (c_rd_valid !== 4'h0) begin failures++; $display("FAIL post_rst_beat got=%b exp=0000", c_rd_valid); end
    @(negedge clock);
    mm_rd_valid = 1'b0; c_rd = 4'b0101; c_burst_len = '0;
    #1;
    checks++; if (err_stray_rd_valid !== 1'b1) begin failures++; $display("FAIL post_rst_stray got=%b exp=1", err_stray_rd_valid); end
    @(negedge clock); #1;
    checks++; if (!(mm_rd === 1'b1 && sole_zero(c_waitrequest) == 0)) begin failures++; $display("FAIL post_rst_grant rd=%b waitreq=%b exp rd=1 waitreq=1110", mm_rd, c_waitrequest); end
    c_rd = '0;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      c_addr[i*AW +: AW] = 32'hA000_0000 + 32'h100 * i;
      c_data_in[i*DW +: DW] = 32'h5555_0000 + i;
    end
    test_reset();
    test_rr_reads();
    test_read_burst();
    test_write_burst();
    test_stray();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
